// File: rtl/ftdi_bus_arb.sv
`timescale 1ns/1ps
// ftdi_bus_arb: FT245-style FIFO bus sequencer; an RX read beats TX writes, and two TX requesters share the bus.
// Optional macro FTDI_TX_RR_EN: round-robin tx0/tx1 arbitration (default build: fixed tx0 priority).
module ftdi_bus_arb #(
  parameter int unsigned RD_WIDTH = 2,
  parameter int unsigned WR_WIDTH = 2,
  parameter int unsigned GAP      = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxf,
  input  logic       txe,
  output logic       oe_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       dq_oe,
  output logic [7:0] dq_out,
  input  logic [7:0] dq_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       tx0_req,
  input  logic [7:0] tx0_data,
  input  logic       tx1_req,
  input  logic [7:0] tx1_data,
  output logic       tx0_ack,
  output logic       tx1_ack,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Handshake: a requester raises txN_req with txN_data and holds both until the
  // one-cycle txN_ack; req/data are sampled only in IDLE, at the grant.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_OE    = 3'd1,
    S_RD_STRB  = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_STRB  = 3'd4,
    S_GAP_WAIT = 3'd5
  } state_t;

  localparam logic [3:0] RD_LAST  = 4'(RD_WIDTH - 1);
  localparam logic [3:0] WR_LAST  = 4'(WR_WIDTH - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d;
  logic [7:0] dq_out_q, dq_out_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       pick_tx1;
`ifdef FTDI_TX_RR_EN
  logic       rr_q, rr_d;

  // rr_q names the requester that wins when both ask.
  assign pick_tx1 = tx1_req && (!tx0_req || rr_q);
`else
  assign pick_tx1 = tx1_req && !tx0_req;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= 1'b0;
      dq_out_q   <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
`ifdef FTDI_TX_RR_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      dq_out_q   <= dq_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
`ifdef FTDI_TX_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    dq_out_d   = dq_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
`ifdef FTDI_TX_RR_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (!rxf) begin
          state_d = S_RD_OE;
        end else if (!txe && (tx0_req || tx1_req)) begin
          state_d  = S_WR_SETUP;
          gnt_d    = pick_tx1;
          dq_out_d = pick_tx1 ? tx1_data : tx0_data;
        end
      end
      S_RD_OE: begin
        state_d = S_RD_STRB;
        cnt_d   = RD_LAST;
      end
      S_RD_STRB: begin
        if (cnt_q == 4'd0) begin
          rx_data_d  = dq_in;
          rx_valid_d = 1'b1;
          state_d    = S_GAP_WAIT;
          cnt_d      = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_STRB;
        cnt_d   = WR_LAST;
      end
      S_WR_STRB: begin
        if (cnt_q == 4'd0) begin
          // Ack lands in the first GAP_WAIT cycle, when wr_n is back high.
          ack0_d  = !gnt_q;
          ack1_d  = gnt_q;
`ifdef FTDI_TX_RR_EN
          rr_d    = !gnt_q;
`endif
          state_d = S_GAP_WAIT;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  assign oe_n      = !(state_q == S_RD_OE || state_q == S_RD_STRB);
  assign rd_n      = (state_q != S_RD_STRB);
  assign wr_n      = (state_q != S_WR_STRB);
  assign dq_oe     = (state_q == S_WR_SETUP || state_q == S_WR_STRB);
  assign busy      = (state_q != S_IDLE);
  assign dq_out    = dq_out_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx0_ack   = ack0_q;
  assign tx1_ack   = ack1_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ftdi_bus_arb.sv
`timescale 1ns/1ps
// tb_ftdi_bus_arb: scoreboard bench; expected bus events come from a transaction-level
// model of read-first, then tx0/tx1 arbitration, compared by a negedge monitor.
module tb_ftdi_bus_arb;

  localparam int RD_W  = 2;
  localparam int WR_W  = 2;
  localparam int GAP_W = 1;
`ifdef FTDI_TX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rxf = 1'b1, txe = 1'b1;
  logic       oe_n, rd_n, wr_n, dq_oe;
  logic [7:0] dq_out, rx_data;
  logic [7:0] dq_in = 8'd0;
  logic       rx_valid;
  logic       tx0_req = 1'b0, tx1_req = 1'b0;
  logic [7:0] tx0_data = 8'd0, tx1_data = 8'd0;
  logic       tx0_ack, tx1_ack, busy;
  logic [2:0] state_dbg;

  ftdi_bus_arb #(.RD_WIDTH(RD_W), .WR_WIDTH(WR_W), .GAP(GAP_W)) dut (
    .clk(clk), .n_rst(n_rst), .rxf(rxf), .txe(txe),
    .oe_n(oe_n), .rd_n(rd_n), .wr_n(wr_n), .dq_oe(dq_oe),
    .dq_out(dq_out), .dq_in(dq_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx0_req(tx0_req), .tx0_data(tx0_data), .tx1_req(tx1_req), .tx1_data(tx1_data),
    .tx0_ack(tx0_ack), .tx1_ack(tx1_ack), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  // Event word: {kind, byte}; kind 0 = rx byte, 1 = tx0 write, 2 = tx1 write.
  logic [9:0] exp_q[$];
  logic [7:0] rxb[$], d0[$], d1[$];
  int  checks = 0, passes = 0;
  bit  rr_model = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_event(input logic [9:0] act);
    logic [9:0] exp;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 1'b0, 32'(act), 32'h3ff);
    end else begin
      exp = exp_q.pop_front();
      chk("bus_event", act == exp, 32'(act), 32'(exp));
    end
  endtask

  task automatic run_len(input bit active, inout int run, input int want, input string name);
    if (active) run++;
    else if (run != 0) begin
      chk(name, run == want, 32'(run), 32'(want));
      run = 0;
    end
  endtask

  // ---------------- monitor ----------------
  int oe_run = 0, rd_run = 0, wr_run = 0, drv_run = 0, busy_run = 0;
  bit saw_rd = 1'b0, saw_wr = 1'b0;

  always @(negedge clk) begin
    if (!n_rst) begin
      oe_run = 0; rd_run = 0; wr_run = 0; drv_run = 0; busy_run = 0;
      saw_rd = 1'b0; saw_wr = 1'b0;
    end else begin
      if (busy) chk("bus_overlap", !((!oe_n) && dq_oe), {30'd0, oe_n, dq_oe}, 32'h2);
      if (rx_valid) cmp_event({2'd0, rx_data});
      if (tx0_ack)  cmp_event({2'd1, dq_out});
      if (tx1_ack)  cmp_event({2'd2, dq_out});
      run_len(!oe_n, oe_run,  RD_W + 1, "oe_n_low_cycles");
      run_len(!rd_n, rd_run,  RD_W,     "rd_n_low_cycles");
      run_len(!wr_n, wr_run,  WR_W,     "wr_n_low_cycles");
      run_len(dq_oe, drv_run, WR_W + 1, "dq_oe_high_cycles");
      if (busy) begin
        busy_run++;
        if (!oe_n) saw_rd = 1'b1;
        if (dq_oe) saw_wr = 1'b1;
      end else if (busy_run != 0) begin
        chk("busy_one_transfer", saw_rd ^ saw_wr, {30'd0, saw_rd, saw_wr}, 32'h1);
        chk("busy_cycles", busy_run == (saw_rd ? 1 + RD_W + GAP_W : 1 + WR_W + GAP_W),
            32'(busy_run), 32'(saw_rd ? 1 + RD_W + GAP_W : 1 + WR_W + GAP_W));
        busy_run = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Reads queued at scenario start all precede writes; writes follow the arbitration rule.
  task automatic model_push();
    int i0, i1;
    bit pick1;
    i0 = 0; i1 = 0;
    foreach (rxb[k]) exp_q.push_back({2'd0, rxb[k]});
    while (i0 < d0.size() || i1 < d1.size()) begin
      pick1 = (i1 < d1.size()) && (!(i0 < d0.size()) || (RR && rr_model));
      if (pick1) begin exp_q.push_back({2'd2, d1[i1]}); i1++; end
      else       begin exp_q.push_back({2'd1, d0[i0]}); i0++; end
      if (RR) rr_model = !pick1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_rd(input logic lvl);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (rd_n !== lvl && t < 400);
    if (rd_n !== lvl) chk("wait_rd_n", 1'b0, 32'(rd_n), 32'(lvl));
  endtask

  task automatic wait_ack(input bit which);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((which ? tx1_ack : tx0_ack) !== 1'b1 && t < 400);
    if ((which ? tx1_ack : tx0_ack) !== 1'b1) chk(which ? "wait_tx1_ack" : "wait_tx0_ack", 1'b0, 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while ((exp_q.size() != 0 || busy) && t < 2000);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 0);
    chk("drain_idle", {oe_n, rd_n, wr_n, dq_oe, busy} == 5'b11100, 32'({oe_n, rd_n, wr_n, dq_oe, busy}), 32'h1c);
  endtask

  task automatic run_scenario(input int txe_dly);
    model_push();
    fork
      begin
        for (int k = 0; k < rxb.size(); k++) begin
          dq_in = rxb[k];
          rxf   = 1'b0;
          wait_rd(1'b0);
          if (k == rxb.size() - 1) rxf = 1'b1;
          wait_rd(1'b1);
        end
      end
      begin
        for (int k = 0; k < d0.size(); k++) begin
          tx0_data = d0[k]; tx0_req = 1'b1;
          wait_ack(1'b0);
        end
        tx0_req = 1'b0;
      end
      begin
        for (int k = 0; k < d1.size(); k++) begin
          tx1_data = d1[k]; tx1_req = 1'b1;
          wait_ack(1'b1);
        end
        tx1_req = 1'b0;
      end
      begin
        repeat (txe_dly) @(negedge clk);
        txe = 1'b0;
      end
    join
    txe = 1'b1;
    drain();
    rxb.delete(); d0.delete(); d1.delete();
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_strobes"}, {oe_n, rd_n, wr_n, dq_oe, busy} == 5'b11100, 32'({oe_n, rd_n, wr_n, dq_oe, busy}), 32'h1c);
    chk({name, "_pulses"}, {rx_valid, tx0_ack, tx1_ack} == 3'b000, 32'({rx_valid, tx0_ack, tx1_ack}), 0);
    chk({name, "_data"}, {dq_out, rx_data} == 16'h0000, 32'({dq_out, rx_data}), 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_reset_state("reset");
    repeat (2) @(negedge clk);
    rr_model = 1'b0;
    #2 n_rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw_busy;
    reset_dut();

    rxb = '{8'hA5};
    run_scenario(0);

    d0 = '{8'h3C};
    run_scenario(0);

    rxb = '{8'h5E}; d1 = '{8'hC3};
    run_scenario(0);

    reset_dut();
    d0 = '{8'h10, 8'h11, 8'h12, 8'h13}; d1 = '{8'h20, 8'h21, 8'h22, 8'h23};
    run_scenario(0);

    // A request withdrawn while txe is high must never reach the bus.
    saw_busy = 1'b0;
    tx1_data = 8'h77; tx1_req = 1'b1;
    repeat (5) begin @(negedge clk); saw_busy |= busy; end
    tx1_req = 1'b0; txe = 1'b0;
    repeat (10) begin @(negedge clk); saw_busy |= busy; end
    txe = 1'b1;
    chk("dropped_req_no_write", !saw_busy, 32'(saw_busy), 0);

    // Reset during the write strobe, then the held request is served afresh.
    tx0_data = 8'h5A; tx0_req = 1'b1; txe = 1'b0;
    begin
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (wr_n !== 1'b0 && t < 100);
      chk("reach_wr_strb", wr_n === 1'b0, 32'(wr_n), 0);
    end
    #2 n_rst = 1'b0;
    #1 check_reset_state("midwrite_reset");
    repeat (2) @(negedge clk);
    rr_model = 1'b0;
    exp_q.push_back({2'd1, 8'h5A});
    #2 n_rst = 1'b1;
    wait_ack(1'b0);
    tx0_req = 1'b0; txe = 1'b1;
    drain();

    for (int s = 0; s < 30; s++) begin
      int nrx, n0, n1;
      nrx = $urandom_range(0, 2);
      n0  = $urandom_range(0, 3);
      n1  = $urandom_range(0, 3);
      for (int k = 0; k < nrx; k++) rxb.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < n0; k++)  d0.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < n1; k++)  d1.push_back(8'($urandom_range(0, 255)));
      run_scenario($urandom_range(0, 15));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ftdi_bus_arb.md
FTDI_BUS_ARB -- requirements
Module: ftdi_bus_arb

Interface
REQ-001 Parameter RD_WIDTH, default 2: cycles rd_n is held low per byte read (legal 1..15).
REQ-002 Parameter WR_WIDTH, default 2: cycles wr_n is held low per byte write (legal 1..15).
REQ-003 Parameter GAP, default 1: idle cycles inserted after every transfer (legal 1..15).
REQ-004 Reset n_rst, asynchronous, active-low; clock clk.
REQ-005 clk  in  1  system clock.
REQ-006 n_rst  in  1  async active-low reset.
REQ-007 rxf  in  1  FIFO RX data available, active-low, pre-synchronised.
REQ-008 txe  in  1  FIFO TX space available, active-low, pre-synchronised.
REQ-009 oe_n  out  1  FIFO output enable, active-low.
REQ-010 rd_n  out  1  FIFO read strobe, active-low.
REQ-011 wr_n  out  1  FIFO write strobe, active-low.
REQ-012 dq_oe  out  1  high = FPGA drives dq pads with dq_out.
REQ-013 dq_out  out  8  write data to pads.
REQ-014 dq_in  in  8  read data from pads.
REQ-015 rx_data  out  8  last byte read; rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-016 tx0_req/tx1_req  in  1  write request, held until ack; tx0_data/tx1_data  in  8  byte.
REQ-017 tx0_ack/tx1_ack  out  1  one-cycle pulse, byte written.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States IDLE, RD_OE, RD_STRB, WR_SETUP, WR_STRB, GAP_WAIT; one-hot or binary, implementer's choice.
REQ-020 IDLE: rxf==0 -> RD_OE; else txe==0 and any tx req -> WR_SETUP; else stay. RX has priority over TX.
REQ-021 RD_OE: oe_n=0 for exactly 1 cycle, then RD_STRB.
REQ-022 RD_STRB: oe_n=0, rd_n=0 for RD_WIDTH cycles; dq_in registered into rx_data on last cycle; rx_valid pulses the following cycle; then GAP_WAIT.
REQ-023 WR_SETUP: grant latched, granted tx data registered into dq_out on entry; dq_oe=1, wr_n=1 for 1 cycle, then WR_STRB.
REQ-024 WR_STRB: dq_oe=1, wr_n=0 for WR_WIDTH cycles; granted ack pulses on the cycle wr_n returns high; then GAP_WAIT.
REQ-025 GAP_WAIT: all strobes high, dq_oe=0 for GAP cycles, then IDLE; dq_oe and oe_n never both active in any cycle.
REQ-026 rxf/txe sampled only in IDLE; a started transfer completes even if rxf/txe deassert mid-transfer.
REQ-027 A req dropped before grant causes no write and no ack; req changes after grant are ignored until ack.
REQ-028 Strobe-width counter 4 bits, reloaded on each state entry, no wrap beyond parameter value.
REQ-029 Without FTDI_TX_RR_EN, tx0 has fixed priority over tx1.

Reset
REQ-030 On n_rst low, asynchronously: state=IDLE, oe_n=rd_n=wr_n=1, dq_oe=0, dq_out=0, rx_data=0, rx_valid=0, tx0_ack=tx1_ack=0, busy=0, counters=0, rr pointer=tx0.
REQ-031 Reset mid-transfer aborts immediately; no ack/rx_valid issued for the aborted byte.

Configuration
REQ-032 Macro FTDI_TX_RR_EN defined: round-robin between tx0/tx1; pointer toggles to the other requester after each ack; with both requesting, grants alternate starting tx0 after reset.
REQ-033 Macro FTDI_TX_RR_EN undefined: fixed priority per REQ-029; no pointer register.

Verification
REQ-034 rxf=0, dq_in=8'hA5, defaults -> oe_n low 3 cycles, rd_n low 2 cycles, rx_data=8'hA5, one rx_valid pulse, busy low after 1 gap cycle.
REQ-035 txe=0, tx0_req=1, tx0_data=8'h3C -> dq_out=8'h3C, dq_oe high 3 cycles, wr_n low 2 cycles, single tx0_ack pulse.
REQ-036 rxf=0, txe=0, tx1_req=1 same cycle -> read completes first, then write of tx1_data; no overlap of dq_oe and oe_n.
REQ-037 tx0_req=tx1_req=1 held for 4 bytes, txe=0 -> RR_EN: acks tx0,tx1,tx0,tx1; no RR_EN: four tx0 acks.
REQ-038 n_rst pulsed low during WR_STRB -> wr_n=1, dq_oe=0 same cycle, no ack; after release new request serviced normally.
